// File: rtl/sigmf_pipe.sv
// Pipelined sigmoid/tanh activation: per-segment 3-term Taylor polynomial on |x|,
// symmetry fold for negative inputs, runtime-loadable coefficient table, valid/ready stream.
module sigmf_pipe #(
  parameter int W          = 16,
  parameter int FRAC       = 10,
  parameter int SEG_BITS   = 3,
  parameter int SEG_W_LOG2 = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [W-1:0]   in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [W-1:0]   out_data,
  input  logic                  cfg_we,
  input  logic [SEG_BITS+1:0]   cfg_addr,
  input  logic signed [W-1:0]   cfg_wdata
);

  localparam int NSEG = 1 << SEG_BITS;
  localparam int NENT = 4 * NSEG;
  localparam int SH   = FRAC + SEG_W_LOG2;
  localparam int D_W  = W + 1;
  localparam int D2_W = 2 * D_W;
  localparam int T2_W = W + D_W;
  localparam int T3_W = W + D2_W;
  localparam int R_W  = W + 2;
  localparam logic signed [R_W-1:0] ONE_R = R_W'(1 << FRAC);

  function automatic logic signed [W-1:0] sat_dbl(input logic signed [W-1:0] x);
    logic [W:0] y;
    y = {x, 1'b0};
    if (y[W] != y[W-1])
      return y[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    return y[W-1:0];
  endfunction

  // Two's complement magnitude; the most negative value maps to 2^(W-1) unsigned.
  function automatic logic [W-1:0] abs_u(input logic signed [W-1:0] x);
    return x[W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic signed [R_W-1:0] clamp_unit(input logic signed [R_W-1:0] v);
    if (v < 0)     return '0;
    if (v > ONE_R) return ONE_R;
    return v;
  endfunction

  logic                 w_adv;
  logic signed [W-1:0]  r_tbl [NENT];

  assign w_adv    = out_ready | ~out_valid;
  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NENT; i++) r_tbl[i] <= '0;
    end else if (cfg_we) begin
      r_tbl[cfg_addr] <= cfg_wdata;
    end
  end

  logic r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
      r_vld_p3 <= 1'b0;
      r_vld_p4 <= 1'b0;
    end else if (w_adv) begin
      r_vld_p1 <= in_valid;
      r_vld_p2 <= r_vld_p1;
      r_vld_p3 <= r_vld_p2;
      r_vld_p4 <= r_vld_p3;
    end
  end

  // S1: prescale, magnitude, segment lookup
  logic signed [W-1:0]   w_xp;
  logic [W-1:0]          w_a;
  logic [W-1:0]          w_idx;
  logic [SEG_BITS-1:0]   w_seg;
  logic                  w_sat;

  assign w_xp  = in_mode ? sat_dbl(in_data) : in_data;
  assign w_a   = abs_u(w_xp);
  assign w_idx = w_a >> SH;
  assign w_sat = (w_idx >= W'(NSEG));
  assign w_seg = w_idx[SEG_BITS-1:0];

  logic [W-1:0]         r_a_p1;
  logic                 r_neg_p1, r_sat_p1, r_mode_p1;
  logic signed [W-1:0]  r_mid_p1, r_c0_p1, r_c1_p1, r_c2_p1;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_a_p1    <= w_a;
      r_neg_p1  <= w_xp[W-1];
      r_sat_p1  <= w_sat;
      r_mode_p1 <= in_mode;
      r_mid_p1  <= r_tbl[{w_seg, 2'd0}];
      r_c0_p1   <= r_tbl[{w_seg, 2'd1}];
      r_c1_p1   <= r_tbl[{w_seg, 2'd2}];
      r_c2_p1   <= r_tbl[{w_seg, 2'd3}];
    end
  end

  // S2: offset from segment midpoint and its square
  logic signed [D_W-1:0]  w_d;
  logic signed [D2_W-1:0] w_dd;

  assign w_d  = $signed({1'b0, r_a_p1}) - $signed({r_mid_p1[W-1], r_mid_p1});
  assign w_dd = w_d * w_d;

  logic signed [D_W-1:0]  r_d_p2;
  logic signed [D2_W-1:0] r_d2_p2;
  logic signed [W-1:0]    r_c0_p2, r_c1_p2, r_c2_p2;
  logic                   r_neg_p2, r_sat_p2, r_mode_p2;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_d_p2    <= w_d;
      r_d2_p2   <= w_dd >>> FRAC;
      r_c0_p2   <= r_c0_p1;
      r_c1_p2   <= r_c1_p1;
      r_c2_p2   <= r_c2_p1;
      r_neg_p2  <= r_neg_p1;
      r_sat_p2  <= r_sat_p1;
      r_mode_p2 <= r_mode_p1;
    end
  end

  // S3: polynomial terms at full product precision
  logic signed [T2_W-1:0] w_p2;
  logic signed [T3_W-1:0] w_p3;

  assign w_p2 = r_c1_p2 * r_d_p2;
  assign w_p3 = r_c2_p2 * r_d2_p2;

  logic signed [R_W-1:0] r_t1_p3, r_t2_p3, r_t3_p3;
  logic                  r_neg_p3, r_sat_p3, r_mode_p3;

  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_t1_p3   <= R_W'(r_c0_p2);
      r_t2_p3   <= R_W'(w_p2 >>> FRAC);
      r_t3_p3   <= R_W'(w_p3 >>> FRAC);
      r_neg_p3  <= r_neg_p2;
      r_sat_p3  <= r_sat_p2;
      r_mode_p3 <= r_mode_p2;
    end
  end

  // S4: sum, clamp, symmetry fold, optional tanh remap
  logic signed [R_W-1:0] w_sum, w_r, w_s, w_o;

  assign w_sum = r_t1_p3 + r_t2_p3 + r_t3_p3;
  assign w_r   = r_sat_p3 ? ONE_R : clamp_unit(w_sum);
  assign w_s   = r_neg_p3 ? ONE_R - w_r : w_r;
  assign w_o   = r_mode_p3 ? (w_s <<< 1) - ONE_R : w_s;

  logic signed [W-1:0] r_out_p4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_p4 <= '0;
    end else if (w_adv) begin
      r_out_p4 <= W'(w_o);
    end
  end

  assign out_valid = r_vld_p4;
  assign out_data  = r_out_p4;

endmodule
